// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared hazard-control types and pipeline constants
package hazard_pkg;

  localparam int REG_IDX_W        = 5;
  localparam int LONG_LAT_DEFAULT = 8;
  // Wide enough for LONG_LAT-2 with LONG_LAT up to 32
  localparam int LAT_CNT_W        = 5;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LONG = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline status in, stall/flush/bubble controls out
interface hazard_ctrl_if;
  import hazard_pkg::*;

  logic [REG_IDX_W-1:0] ifid_rs1;
  logic [REG_IDX_W-1:0] ifid_rs2;
  logic                 ifid_rs1_used;
  logic                 ifid_rs2_used;
  logic [REG_IDX_W-1:0] idex_rd;
  logic                 idex_is_load;
  logic                 idex_is_long;
  logic                 idex_valid;
  logic                 ex_redirect;
  logic                 mem_stall;

  logic                 stall_pc;
  logic                 stall_ifid;
  logic                 stall_idex;
  logic                 stall_exmem;
  logic                 flush_ifid;
  logic                 bubble_idex;
  logic                 bubble_exmem;
  logic                 long_done;
  logic [31:0]          stall_cnt;

  modport master (
    output ifid_rs1, ifid_rs2, ifid_rs1_used, ifid_rs2_used,
           idex_rd, idex_is_load, idex_is_long, idex_valid,
           ex_redirect, mem_stall,
    input  stall_pc, stall_ifid, stall_idex, stall_exmem,
           flush_ifid, bubble_idex, bubble_exmem, long_done, stall_cnt
  );

  modport slave (
    input  ifid_rs1, ifid_rs2, ifid_rs1_used, ifid_rs2_used,
           idex_rd, idex_is_load, idex_is_long, idex_valid,
           ex_redirect, mem_stall,
    output stall_pc, stall_ifid, stall_idex, stall_exmem,
           flush_ifid, bubble_idex, bubble_exmem, long_done, stall_cnt
  );

endinterface

// File: rtl/hazard_ctrl_lat_counter.sv
// rtl/hazard_ctrl_lat_counter.sv - loadable down-counter timing a long EX op
module lat_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use, long-op, redirect and memory-stall hazard control
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LONG_LAT = LONG_LAT_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  // The start cycle plus the final done cycle account for two of LONG_LAT
  localparam logic [LAT_CNT_W-1:0] LOAD_VAL = LAT_CNT_W'(LONG_LAT - 2);

  hz_state_t            state;
  hz_state_t            state_nxt;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_zero;
  logic [LAT_CNT_W-1:0] cnt;
  logic                 long_start;
  logic                 load_use;
  logic                 s_pc, s_ifid, s_idex, s_exmem;
  logic                 f_ifid, b_idex, b_exmem, done;
  logic [31:0]          stall_cnt;

  assign long_start = hz.idex_valid && hz.idex_is_long;
  assign load_use   = hz.idex_valid && hz.idex_is_load && (hz.idex_rd != '0) &&
                      ((hz.ifid_rs1_used && (hz.ifid_rs1 == hz.idex_rd)) ||
                       (hz.ifid_rs2_used && (hz.ifid_rs2 == hz.idex_rd)));

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    s_pc      = 1'b0;
    s_ifid    = 1'b0;
    s_idex    = 1'b0;
    s_exmem   = 1'b0;
    f_ifid    = 1'b0;
    b_idex    = 1'b0;
    b_exmem   = 1'b0;
    done      = 1'b0;
    if (!rst) begin
      case (state)
        ST_RUN: begin
          if (hz.mem_stall) begin
            {s_pc, s_ifid, s_idex, s_exmem} = 4'b1111;
          end else if (hz.ex_redirect) begin
            f_ifid = 1'b1;
            b_idex = 1'b1;
          end else if (long_start) begin
            {s_pc, s_ifid, s_idex, b_exmem} = 4'b1111;
            cnt_load  = 1'b1;
            state_nxt = ST_LONG;
          end else if (load_use) begin
            {s_pc, s_ifid, b_idex} = 3'b111;
          end
        end
        ST_LONG: begin
          // Redirects cannot resolve while the long op owns EX, so they are ignored here
          if (hz.mem_stall) begin
            {s_pc, s_ifid, s_idex, s_exmem} = 4'b1111;
          end else if (cnt_zero) begin
            done      = 1'b1;
            state_nxt = ST_RUN;
          end else begin
            {s_pc, s_ifid, s_idex, b_exmem} = 4'b1111;
            cnt_dec = 1'b1;
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (s_pc && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  lat_counter #(.W(LAT_CNT_W)) u_lat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (LOAD_VAL),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  assign hz.stall_pc     = s_pc;
  assign hz.stall_ifid   = s_ifid;
  assign hz.stall_idex   = s_idex;
  assign hz.stall_exmem  = s_exmem;
  assign hz.flush_ifid   = f_ifid;
  assign hz.bubble_idex  = b_idex;
  assign hz.bubble_exmem = b_exmem;
  assign hz.long_done    = done;
  assign hz.stall_cnt    = stall_cnt;

endmodule
